cpu_divmod_ctrl: RTL and testbench
==================================

Name: cpu_divmod_ctrl

Overview:
- Sequencer between the CPU exec stage and the two shared integer dividers, divmod32 and divmod64.
- Accepts one divide request at a time and steers it to the unit selected by operand width.
- Issues a single-cycle enable, waits for data_ready, then holds the quotient/remainder until the exec stage consumes it.
- Handles divide-by-zero locally, aborts on interrupt/flush, and enforces a watchdog timeout so the exec stage can never hang.

Parameters:
- TIMEOUT_CYCLES, 80, WAIT-state cycles before giving up on a divider.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  exec stage requests a divide.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_wide  in  1  0 = 32-bit op (divmod32), 1 = 64-bit op (divmod64).
- req_signed  in  1  1 = signed divide; driven to unit's unsgn_or_sgn.
- req_num  in  64  numerator; only [31:0] used when req_wide=0.
- req_denom  in  64  denominator; only [31:0] used when req_wide=0.
- abort  in  1  interrupt/flush: cancel any in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  exec stage consumes result.
- resp_quot  out  64  quotient, zero-extended in 32-bit mode.
- resp_rem  out  64  remainder, zero-extended in 32-bit mode.
- resp_div_zero  out  1  result came from the divide-by-zero path.
- resp_timeout  out  1  result came from watchdog expiry.
- d32_enable  out  1  one-cycle command strobe to divmod32.
- d32_unsgn_or_sgn  out  1  signedness to divmod32.
- d32_num  out  32  numerator to divmod32.
- d32_denom  out  32  denominator to divmod32.
- d32_can_accept_cmd  in  1  divmod32 idle.
- d32_data_ready  in  1  divmod32 result valid.
- d32_quot  in  32  divmod32 quotient.
- d32_rem  in  32  divmod32 remainder.
- d64_enable, d64_unsgn_or_sgn, d64_num[63:0], d64_denom[63:0], d64_can_accept_cmd, d64_data_ready, d64_quot[63:0], d64_rem[63:0]: same as the d32_* ports, for divmod64.

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, every other output 0, counter 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch wide/signed/num/denom.
  - If the selected-width denom is 0: go to DONE with resp_div_zero=1, resp_quot = all ones of op width (0x00000000_FFFFFFFF in 32-bit mode), resp_rem = num (zero-extended).
  - Otherwise go to ISSUE.
- ISSUE:
  - Operands and unsgn_or_sgn are driven to the selected unit continuously from ISSUE through WAIT; the unselected unit sees enable=0.
  - If the selected can_accept_cmd=1, assert that unit's enable for exactly this cycle and go to WAIT, with counter cleared to 0.
  - Otherwise stay in ISSUE with enable=0; no timeout applies in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - If the selected data_ready is sampled 1: capture quot/rem (zero-extend d32 results) and go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: go to DONE with resp_timeout=1 and quot=rem=0.
  - data_ready from the unselected unit is ignored.
- DONE:
  - resp_valid=1; the result and flags stay stable until resp_ready=1.
  - On the handshake cycle, go to IDLE; resp_valid and flags clear next cycle.
  - Back-to-back requests therefore have one IDLE cycle between them.
- Latency:
  - Divide-by-zero: accepted at cycle 0, resp_valid at cycle 1.
  - Normal: accepted at cycle 0; enable at cycle 1 if the unit is free; data_ready sampled at cycle k gives resp_valid at cycle k+1.
- abort: from any state, go to IDLE next cycle.
  - enable is forced 0 in the abort cycle.
  - resp_valid is dropped.
  - abort has priority over req_valid, resp_ready, data_ready and timeout in the same cycle.
  - A late data_ready after abort is ignored, because IDLE never samples it.
- Simultaneous data_ready and timeout in the same WAIT cycle: data_ready wins, resp_timeout=0.
- Signed overflow (MIN/-1) is not special-cased; the divider result is passed through.

Test Plan:
- 32-bit unsigned: num=100, denom=7, d32 can_accept=1, data_ready 5 cycles after enable with quot=14/rem=2 -> d32_enable high exactly 1 cycle; resp_valid with quot=14, rem=2, upper 32 bits 0, flags 0.
- 64-bit signed: num=-100, denom=7 -> d64_enable pulse with d64_unsgn_or_sgn=1, d32_enable never high; divider's quot=-14/rem=-2 passed through unchanged.
- Divide by zero, 32-bit, num=0x1234 -> no enable pulse; resp_valid the cycle after acceptance; quot=0x00000000_FFFFFFFF, rem=0x1234, resp_div_zero=1. Repeat with req_wide=1, denom=0x1_00000000 -> NOT zero, dispatched to d64.
- Busy unit: d32_can_accept_cmd low for 4 cycles -> stays in ISSUE with enable=0 and no timeout; enable fires the first cycle it goes high. Then hold resp_ready=0 for 3 cycles -> result stable; one idle cycle before req_ready is seen again.
- Timeout: TIMEOUT_CYCLES=80, data_ready never asserted -> resp_valid exactly 81 cycles after the enable cycle, resp_timeout=1, quot=rem=0. Separately, data_ready on the final count cycle -> normal result, timeout=0.
- Abort in WAIT, then data_ready next cycle -> IDLE, no resp_valid, req_ready=1. Abort in DONE with resp_ready=1 -> IDLE. Assert rst_n low mid-WAIT -> all outputs reset immediately (asynchronously).

Source files
------------

// File: rtl/cpu_divmod_ctrl.sv
// Sequencer between the exec stage and the shared divmod32/divmod64 units:
// dispatch by width, local divide-by-zero, abort, and a WAIT watchdog.
module cpu_divmod_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 80,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wide,
  input  logic        req_signed,
  input  logic [63:0] req_num,
  input  logic [63:0] req_denom,
  input  logic        abort,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_quot,
  output logic [63:0] resp_rem,
  output logic        resp_div_zero,
  output logic        resp_timeout,
  output logic        d32_enable,
  output logic        d32_unsgn_or_sgn,
  output logic [31:0] d32_num,
  output logic [31:0] d32_denom,
  input  logic        d32_can_accept_cmd,
  input  logic        d32_data_ready,
  input  logic [31:0] d32_quot,
  input  logic [31:0] d32_rem,
  output logic        d64_enable,
  output logic        d64_unsgn_or_sgn,
  output logic [63:0] d64_num,
  output logic [63:0] d64_denom,
  input  logic        d64_can_accept_cmd,
  input  logic        d64_data_ready,
  input  logic [63:0] d64_quot,
  input  logic [63:0] d64_rem
);

  localparam int unsigned DW = 64;
  localparam int unsigned HW = 32;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wide_q, wide_d, sgn_q, sgn_d;
  logic [DW-1:0]    num_q, num_d, denom_q, denom_d;
  logic [DW-1:0]    quot_q, quot_d, rem_q, rem_d;
  logic             dz_q, dz_d, to_q, to_d;

  logic             active, sel_accept, sel_ready, req_zero;
  logic [DW-1:0]    sel_quot, sel_rem;

  // Selected-unit views; narrow results are zero-extended.
  assign active     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign sel_accept = wide_q ? d64_can_accept_cmd : d32_can_accept_cmd;
  assign sel_ready  = wide_q ? d64_data_ready : d32_data_ready;
  assign sel_quot   = wide_q ? d64_quot : {HW'(0), d32_quot};
  assign sel_rem    = wide_q ? d64_rem  : {HW'(0), d32_rem};
  assign req_zero   = req_wide ? (req_denom == DW'(0)) : (req_denom[HW-1:0] == HW'(0));

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = (state_q == S_DONE);
  assign resp_quot        = quot_q;
  assign resp_rem         = rem_q;
  assign resp_div_zero    = dz_q;
  assign resp_timeout     = to_q;
  assign d32_unsgn_or_sgn = active && !wide_q && sgn_q;
  assign d32_num          = (active && !wide_q) ? num_q[HW-1:0]   : HW'(0);
  assign d32_denom        = (active && !wide_q) ? denom_q[HW-1:0] : HW'(0);
  assign d64_unsgn_or_sgn = active && wide_q && sgn_q;
  assign d64_num          = (active && wide_q) ? num_q   : DW'(0);
  assign d64_denom        = (active && wide_q) ? denom_q : DW'(0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wide_q  <= 1'b0;
      sgn_q   <= 1'b0;
      num_q   <= '0;
      denom_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wide_q  <= wide_d;
      sgn_q   <= sgn_d;
      num_q   <= num_d;
      denom_q <= denom_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wide_d     = wide_q;
    sgn_d      = sgn_q;
    num_d      = num_q;
    denom_d    = denom_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    to_d       = to_q;
    d32_enable = 1'b0;
    d64_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wide_d  = req_wide;
          sgn_d   = req_signed;
          num_d   = req_num;
          denom_d = req_denom;
          if (req_zero) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
            to_d    = 1'b0;
            quot_d  = req_wide ? {DW{1'b1}} : {HW'(0), {HW{1'b1}}};
            rem_d   = req_wide ? req_num : {HW'(0), req_num[HW-1:0]};
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (sel_accept) begin
          d32_enable = !wide_q;
          d64_enable = wide_q;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A result on the last count cycle still beats the watchdog.
        if (sel_ready) begin
          quot_d  = sel_quot;
          rem_d   = sel_rem;
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          quot_d  = '0;
          rem_d   = '0;
          dz_d    = 1'b0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          quot_d  = '0;
          rem_d   = '0;
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything else in the same cycle.
    if (abort) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      quot_d     = '0;
      rem_d      = '0;
      dz_d       = 1'b0;
      to_d       = 1'b0;
      d32_enable = 1'b0;
      d64_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_divmod_ctrl.sv
// Directed bench for cpu_divmod_ctrl: vector table for full transactions,
// plus hand sequences for abort and asynchronous reset.
module tb_cpu_divmod_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wide, req_signed;
  logic [63:0] req_num, req_denom;
  logic        abort;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_quot, resp_rem;
  logic        resp_div_zero, resp_timeout;
  logic        d32_enable, d32_unsgn_or_sgn;
  logic [31:0] d32_num, d32_denom;
  logic        d32_can_accept_cmd, d32_data_ready;
  logic [31:0] d32_quot, d32_rem;
  logic        d64_enable, d64_unsgn_or_sgn;
  logic [63:0] d64_num, d64_denom;
  logic        d64_can_accept_cmd, d64_data_ready;
  logic [63:0] d64_quot, d64_rem;

  int n_checks = 0;
  int n_errors = 0;

  cpu_divmod_ctrl #(.TIMEOUT_CYCLES(80), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide),
    .req_signed(req_signed), .req_num(req_num), .req_denom(req_denom),
    .abort(abort),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quot(resp_quot), .resp_rem(resp_rem),
    .resp_div_zero(resp_div_zero), .resp_timeout(resp_timeout),
    .d32_enable(d32_enable), .d32_unsgn_or_sgn(d32_unsgn_or_sgn),
    .d32_num(d32_num), .d32_denom(d32_denom),
    .d32_can_accept_cmd(d32_can_accept_cmd), .d32_data_ready(d32_data_ready),
    .d32_quot(d32_quot), .d32_rem(d32_rem),
    .d64_enable(d64_enable), .d64_unsgn_or_sgn(d64_unsgn_or_sgn),
    .d64_num(d64_num), .d64_denom(d64_denom),
    .d64_can_accept_cmd(d64_can_accept_cmd), .d64_data_ready(d64_data_ready),
    .d64_quot(d64_quot), .d64_rem(d64_rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wide;
    logic        sgn;
    logic [63:0] num;
    logic [63:0] denom;
    int          busy;   // cycles the selected unit refuses commands
    int          lat;    // data_ready this many cycles after enable; 0 = never
    int          hold;   // extra DONE cycles with resp_ready low
    logic [63:0] dq;
    logic [63:0] dr;
    logic [63:0] eq;
    logic [63:0] er;
    logic        edz;
    logic        eto;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_wide = 1'b0; req_signed = 1'b0;
    req_num = '0; req_denom = '0; abort = 1'b0; resp_ready = 1'b0;
    d32_can_accept_cmd = 1'b1; d32_data_ready = 1'b0; d32_quot = '0; d32_rem = '0;
    d64_can_accept_cmd = 1'b1; d64_data_ready = 1'b0; d64_quot = '0; d64_rem = '0;
  endtask

  task automatic check_resp(input string tag, input vec_t v);
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_quot"}, resp_quot, v.eq);
    chk({tag, "_rem"}, resp_rem, v.er);
    chk({tag, "_dz"}, 64'(resp_div_zero), 64'(v.edz));
    chk({tag, "_to"}, 64'(resp_timeout), 64'(v.eto));
  endtask

  task automatic run_vec(input vec_t v);
    int nwait;
    logic sel_en, oth_en;
    @(negedge clk);
    req_valid = 1'b1; req_wide = v.wide; req_signed = v.sgn;
    req_num = v.num; req_denom = v.denom;
    #1 chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_num = '0; req_denom = '0;
    if (v.edz) begin
      #1;
      chk("dz_no_en", 64'({d32_enable, d64_enable}), 64'd0);
      check_resp("dz", v);
    end else begin
      for (int i = 0; i <= v.busy; i++) begin
        if (i > 0) @(negedge clk);
        d32_can_accept_cmd = v.wide ? 1'b1 : (i >= v.busy);
        d64_can_accept_cmd = v.wide ? (i >= v.busy) : 1'b1;
        #1;
        sel_en = v.wide ? d64_enable : d32_enable;
        oth_en = v.wide ? d32_enable : d64_enable;
        chk("issue_en", 64'(sel_en), 64'(i >= v.busy));
        chk("issue_other_en", 64'(oth_en), 64'd0);
        chk("issue_no_valid", 64'(resp_valid), 64'd0);
        if (v.wide) begin
          chk("op64_num", d64_num, v.num);
          chk("op64_denom", d64_denom, v.denom);
          chk("op64_sgn", 64'(d64_unsgn_or_sgn), 64'(v.sgn));
        end else begin
          chk("op32_num", 64'(d32_num), {32'd0, v.num[31:0]});
          chk("op32_denom", 64'(d32_denom), {32'd0, v.denom[31:0]});
          chk("op32_sgn", 64'(d32_unsgn_or_sgn), 64'(v.sgn));
        end
      end
      nwait = (v.lat == 0) ? 80 : v.lat;
      for (int j = 1; j <= nwait; j++) begin
        @(negedge clk);
        d32_can_accept_cmd = 1'b1; d64_can_accept_cmd = 1'b1;
        if (v.wide) begin
          d64_quot = v.dq; d64_rem = v.dr;
          d32_quot = 32'hDEAD_BEEF; d32_rem = 32'hDEAD_BEEF;
          d64_data_ready = (v.lat != 0) && (j == nwait);
          d32_data_ready = (j == 1);
        end else begin
          d32_quot = v.dq[31:0]; d32_rem = v.dr[31:0];
          d64_quot = 64'hBADBAD; d64_rem = 64'hBADBAD;
          d32_data_ready = (v.lat != 0) && (j == nwait);
          d64_data_ready = (j == 1);
        end
        #1;
        chk("wait_en", 64'({d32_enable, d64_enable}), 64'd0);
        chk("wait_no_valid", 64'(resp_valid), 64'd0);
      end
      @(negedge clk);
      d32_data_ready = 1'b0; d64_data_ready = 1'b0;
      #1 check_resp("done", v);
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      #1 check_resp("hold", v);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("post_valid", 64'(resp_valid), 64'd0);
    chk("post_req_ready", 64'(req_ready), 64'd1);
    chk("post_flags", 64'({resp_div_zero, resp_timeout}), 64'd0);
  endtask

  // Accept a 32-bit 10/3 request and bring it to the enable cycle.
  task automatic start_32();
    @(negedge clk);
    req_valid = 1'b1; req_wide = 1'b0; req_signed = 1'b0;
    req_num = 64'd10; req_denom = 64'd3;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 64'd100, 64'd7, 0, 5, 0, 64'd14, 64'd2, 64'd14, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 3, 0,
                64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE,
                64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 64'h5555_0000_0000_1234, 64'hABCD_0000_0000_0000, 0, 0, 0,
                64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF, 64'h1234, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 64'h5_0000_0003, 64'h1_0000_0000, 0, 2, 0,
                64'd5, 64'd3, 64'd5, 64'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 64'h7777_7777_FFFF_FFF9, 64'd2, 4, 2, 3,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 64'd50, 64'd5, 0, 0, 0, 64'd10, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 64'd19, 64'd2, 0, 80, 0, 64'd9, 64'd1, 64'd9, 64'd1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 64'h8000_0000_0000_0001, 64'd0, 0, 0, 0,
                64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_en", 64'({d32_enable, d64_enable}), 64'd0);
    chk("rst_quot", resp_quot, 64'd0);
    chk("rst_d64_num", d64_num, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Abort in ISSUE: enable must be suppressed even though the unit is free.
    start_32();
    abort = 1'b1;
    #1 chk("abort_issue_en", 64'(d32_enable), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    #1 chk("abort_issue_idle", 64'(req_ready), 64'd1);

    // Abort in WAIT, then a late data_ready that must be ignored.
    start_32();
    #1 chk("abort_wait_en", 64'(d32_enable), 64'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; d32_data_ready = 1'b1; d32_quot = 32'd3; d32_rem = 32'd1;
    #1;
    chk("abort_wait_idle", 64'(req_ready), 64'd1);
    chk("abort_wait_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    d32_data_ready = 1'b0;
    #1;
    chk("late_ready_ignored", 64'(resp_valid), 64'd0);
    chk("late_ready_idle", 64'(req_ready), 64'd1);

    // Abort in DONE together with resp_ready.
    @(negedge clk);
    req_valid = 1'b1; req_wide = 1'b0; req_num = 64'd9; req_denom = 64'd0;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("abort_done_pre", 64'(resp_valid), 64'd1);
    abort = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; resp_ready = 1'b0;
    #1;
    chk("abort_done_valid", 64'(resp_valid), 64'd0);
    chk("abort_done_dz", 64'(resp_div_zero), 64'd0);
    chk("abort_done_idle", 64'(req_ready), 64'd1);

    // Asynchronous reset in the middle of WAIT.
    start_32();
    @(negedge clk);
    #1 chk("mid_wait_num", 64'(d32_num), 64'd10);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_ready", 64'(req_ready), 64'd1);
    chk("async_rst_num", 64'(d32_num), 64'd0);
    chk("async_rst_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("after_rst_idle", 64'(req_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
